// File: rtl/demux8_if.sv
// Bit-collector bus: upstream bit offers (in_*) and the assembled-word
// handshake (out_*). dbg_state mirrors the collector FSM for observation.
//
// Handshake rules: a bit transfers on a rising edge where in_valid && in_ready;
// a word transfers on a rising edge where out_valid && out_ready. A source may
// raise valid without waiting for ready; a sink may raise ready at any time.
interface demux8_if;
  logic       in_valid;
  logic       in_bit;
  logic [2:0] in_sel;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_mask;
  logic       out_ready;
  logic       dbg_state;

  // Upstream bit source and downstream word sink, seen from outside the block.
  modport master (
    output in_valid, in_bit, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mask, dbg_state
  );

  // The collector itself.
  modport slave (
    input  in_valid, in_bit, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mask, dbg_state
  );
endinterface

// File: rtl/demux8_collector.sv
// demux8_collector: steers single bits into positions of an 8-bit word and
// presents the word once it is full or closed early by in_last.
//
// Optional feature (macro DEMUX8_AUTO_SEL_EN): in_sel is ignored and an
// internal 3-bit position counter picks the destination, advancing once per
// accepted bit and restarting at 0 whenever a word closes or on reset.
//
// Two states: COLLECT accepts bits (in_ready=1); HOLD presents the word
// (out_valid=1) until out_ready is seen. Handshake flags are decoded straight
// from the state register, so reset clears them without waiting for a clock.
module demux8_collector (
  input  logic    clk,
  input  logic    rst_n,
  demux8_if.slave bus
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] dest;
  logic       accept;

  assign accept = (state_q == COLLECT) && bus.in_valid;

`ifdef DEMUX8_AUTO_SEL_EN
  logic [2:0] pos_q, pos_d;

  assign dest = pos_q;

  // Position counter: next slot after each accepted bit, back to 0 when the word closes.
  always_comb begin
    pos_d = pos_q;
    if (accept) begin
      if (state_d == HOLD) begin
        pos_d = 3'd0;
      end else begin
        pos_d = pos_q + 3'd1;
      end
    end
  end

  // Position counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= 3'd0;
    end else begin
      pos_q <= pos_d;
    end
  end
`else
  assign dest = bus.in_sel;
`endif

  // Next-state and word update: write bits while collecting, clear on hand-off.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          data_d[dest] = bus.in_bit;
          mask_d[dest] = 1'b1;
          // The word closes on an explicit last bit or once every slot is written.
          if (bus.in_last || (mask_d == 8'hFF)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Inputs are ignored here; only the downstream take releases the word.
        if (bus.out_ready) begin
          data_d  = 8'h00;
          mask_d  = 8'h00;
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and word registers; reset drops any partial or held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      data_q  <= 8'h00;
      mask_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_mask  = mask_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_demux8_collector.sv
// Directed bench for demux8_collector. Inputs change and outputs are sampled
// on the falling clock edge; completed words are predicted into exp_q as
// {mask, data} when the closing bit is driven and checked when presented.
module tb_demux8_collector;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] exp_q[$];

  demux8_if bus();

  demux8_collector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one bit for one clock; starts and ends on a falling edge.
  task automatic send_bit(input logic [2:0] sel, input logic b, input logic last);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_bit   = b;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait (bounded) for a presented word and compare it with the oldest prediction.
  task automatic collect_word(input string tag);
    int n;
    logic [15:0] exp;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      check({tag, "_valid_timeout"}, {15'd0, bus.out_valid}, 16'd1);
    end else begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL %s_unexpected_word observed=%h expected=none", tag, {bus.out_mask, bus.out_data});
      end
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check({tag, "_word"}, {bus.out_mask, bus.out_data}, exp);
      end
    end
  endtask

  // Take the held word and confirm the block is empty and collecting again.
  task automatic release_word(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_cleared"}, {bus.out_mask, bus.out_data}, 16'h0000);
    check({tag, "_ready_back"}, {14'd0, bus.in_ready, bus.out_valid}, 16'h0002);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_sel    = 3'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("reset_state", {bus.out_mask, bus.out_data}, 16'h0000);
    check("reset_flags", {14'd0, bus.in_ready, bus.out_valid}, 16'h0002);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

`ifndef DEMUX8_AUTO_SEL_EN
    // Full word 1,0,1,1,0,0,1,0 into positions 0..7, downstream not ready.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat;
      pat = 8'b0100_1101;
      check("s1_ready_while_collecting", {15'd0, bus.in_ready}, 16'd1);
      if (i == 7) exp_q.push_back({8'hFF, 8'h4D});
      send_bit(3'(i), pat[i], 1'b0);
    end
    check("s1_latency", {14'd0, bus.in_ready, bus.out_valid}, 16'h0001);
    repeat (2) @(negedge clk);
    check("s1_ready_held_low", {15'd0, bus.in_ready}, 16'd0);
    collect_word("s1");
    release_word("s1");

    // Early close: pos 3 then pos 5 with last.
    send_bit(3'd3, 1'b1, 1'b0);
    check("s2_partial", {bus.out_mask, bus.out_data, 7'd0, bus.out_valid} >> 8, 16'h0808);
    exp_q.push_back({8'h28, 8'h28});
    send_bit(3'd5, 1'b1, 1'b1);
    check("s2_latency", {15'd0, bus.out_valid}, 16'd1);
    collect_word("s2");
    release_word("s2");

    // Overwrite of the same position: data follows the last write, mask stays one bit.
    send_bit(3'd2, 1'b1, 1'b0);
    exp_q.push_back({8'h04, 8'h00});
    send_bit(3'd2, 1'b0, 1'b1);
    collect_word("s3");
    release_word("s3");

    // Single last bit into an empty word, then upstream keeps offering in HOLD.
    exp_q.push_back({8'h02, 8'h02});
    send_bit(3'd1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_sel   = 3'($urandom_range(0, 7));
      bus.in_bit   = 1'($urandom_range(0, 1));
      bus.in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("s4_hold_stable", {bus.out_mask, bus.out_data}, 16'h0202);
      check("s4_hold_flags", {14'd0, bus.in_ready, bus.out_valid}, 16'h0001);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    collect_word("s4");
    release_word("s4");

    // out_ready while collecting changes nothing.
    bus.out_ready = 1'b1;
    send_bit(3'd0, 1'b1, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("s5_ready_in_collect", {bus.out_mask, bus.out_data}, 16'h0101);
    check("s5_no_output", {15'd0, bus.out_valid}, 16'd0);
    exp_q.push_back({8'h81, 8'h01});
    send_bit(3'd7, 1'b0, 1'b1);
    collect_word("s5");
    release_word("s5");

    // Reset mid-word after four bits: cleared without a clock edge.
    for (int i = 0; i < 4; i++) send_bit(3'(i), 1'b1, 1'b0);
    check("s6_before_reset", {bus.out_mask, bus.out_data}, 16'h0F0F);
    rst_n = 1'b0;
    #1;
    check("s6_reset_word", {bus.out_mask, bus.out_data}, 16'h0000);
    check("s6_reset_flags", {14'd0, bus.in_ready, bus.out_valid}, 16'h0002);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({8'h10, 8'h10});
    send_bit(3'd4, 1'b1, 1'b1);
    collect_word("s6");
    release_word("s6");

    // Reset while holding a word: the word is dropped, never handed off.
    send_bit(3'd6, 1'b1, 1'b1);
    check("s7_holding", {bus.out_mask, bus.out_data, 7'd0, bus.out_valid} >> 8, 16'h4040);
    rst_n = 1'b0;
    #1;
    check("s7_reset_in_hold", {bus.out_mask, bus.out_data}, 16'h0000);
    check("s7_reset_flags", {14'd0, bus.in_ready, bus.out_valid}, 16'h0002);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({8'h01, 8'h00});
    send_bit(3'd0, 1'b0, 1'b1);
    collect_word("s7");
    release_word("s7");
`else
    // Counter-steered: eight ones with random in_sel fill the word in order.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back({8'hFF, 8'hFF});
      send_bit(3'($urandom_range(0, 7)), 1'b1, 1'b0);
    end
    check("a1_latency", {14'd0, bus.in_ready, bus.out_valid}, 16'h0001);
    collect_word("a1");
    release_word("a1");

    // Three bits closed by last land in positions 0..2.
    send_bit(3'd6, 1'b1, 1'b0);
    send_bit(3'd6, 1'b0, 1'b0);
    exp_q.push_back({8'h07, 8'h05});
    send_bit(3'd6, 1'b1, 1'b1);
    collect_word("a2");
    release_word("a2");

    // Reset mid-word returns the counter to position 0.
    for (int i = 0; i < 4; i++) send_bit(3'd7, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("a3_reset_word", {bus.out_mask, bus.out_data}, 16'h0000);
    check("a3_reset_flags", {14'd0, bus.in_ready, bus.out_valid}, 16'h0002);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({8'h01, 8'h01});
    send_bit(3'd5, 1'b1, 1'b1);
    collect_word("a3");
    release_word("a3");
`endif

    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux8_collector.md
DEMUX8_COLLECTOR -- requirements
Module: demux8_collector

Interface
REQ-001 SHALL provide ports (direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  upstream offers one bit this cycle.
- in_bit  in  1  data bit offered.
- in_sel  in  3  destination bit position 0..7 of the offered bit.
- in_last  in  1  offered bit closes the current word early.
- in_ready  out  1  block accepts the offered bit this cycle.
- out_valid  out  1  assembled word available.
- out_data  out  8  assembled word; bit k = last bit written to position k.
- out_mask  out  8  bit k = 1 when position k was written in this word.
- out_ready  in  1  downstream takes the word this cycle.
REQ-002 SHALL make a transfer on the input side occur exactly when in_valid && in_ready at a rising edge; the output side transfers when out_valid && out_ready.

Function
REQ-003 SHALL implement two states: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-004 In COLLECT, an accepted bit SHALL be written to out_data[in_sel] and SHALL set out_mask[in_sel] at that same edge.
REQ-005 A repeated write to an already-written position SHALL overwrite out_data at that position; out_mask is unchanged.
REQ-006 COLLECT SHALL transition to HOLD at the edge that accepts a bit with in_last=1, or at the edge at which out_mask becomes 8'hFF.
REQ-007 out_valid SHALL rise in the cycle after the completing edge; latency from the final accepted bit to out_valid is 1 cycle.
REQ-008 In HOLD, out_data and out_mask SHALL stay stable, and in_valid, in_bit, in_sel and in_last SHALL be ignored.
REQ-009 In HOLD, out_ready=1 SHALL clear out_data and out_mask to 0 and return the block to COLLECT at that edge; in_ready is 1 in the next cycle.
REQ-010 out_ready asserted in COLLECT SHALL have no effect.
REQ-011 A single accepted bit with in_last=1 into an empty word SHALL produce a word whose out_mask has exactly one bit set.
REQ-012 Upstream SHALL observe a one-cycle in_ready=0 bubble per word minimum (HOLD lasts at least 1 cycle).

Reset
REQ-013 rst_n=0 SHALL immediately force COLLECT, out_data=8'h00, out_mask=8'h00, out_valid=0 and in_ready=1, independent of clk.
REQ-014 Reset asserted mid-word or in HOLD SHALL discard the partial or held word without producing an output transfer.
REQ-015 After rst_n deasserts, the first rising edge SHALL be able to accept a bit.

Configuration
REQ-016 Macro DEMUX8_AUTO_SEL_EN defined: in_sel SHALL be ignored, and an internal 3-bit position counter (reset value 0) SHALL select the destination, incrementing by 1 per accepted bit with 7->0 wrap.
REQ-017 With DEMUX8_AUTO_SEL_EN, the counter SHALL return to 0 on the transition to HOLD and on reset.
REQ-018 Without the macro, the destination SHALL be in_sel and no counter SHALL exist.

Verification
REQ-019 Bench SHALL cover the following directed scenarios:
- Write bits 1,0,1,1,0,0,1,0 to in_sel 0..7, out_ready=0 -> out_valid=1 one cycle after 8th bit, out_data=8'h4D, out_mask=8'hFF, in_ready=0 held.
- Writes in_sel=3 bit=1, then in_sel=5 bit=1 with in_last=1 -> out_data=8'h28, out_mask=8'h28; out_ready=1 -> next cycle out_data=0, out_mask=0, in_ready=1.
- in_sel=2 bit=1, then in_sel=2 bit=0 with in_last=1 -> out_data=8'h00, out_mask=8'h04.
- HOLD with in_valid=1 toggling for 5 cycles -> out_data/out_mask unchanged; no bits absorbed.
- rst_n low for 1 cycle after 4 bits written -> out_mask=0, out_valid=0, in_ready=1 immediately; next word starts clean.
- DEMUX8_AUTO_SEL_EN, 8 bits all 1 with random in_sel -> out_data=8'hFF; a following 3-bit word with in_last on bit 3 -> out_mask=8'h07.
